miriscv_im_arb: RTL and testbench
=================================

MIRISCV_IM_ARB -- requirements
Module: miriscv_im_arb

Interface
REQ-001 The block SHALL have parameter BASE_HI, default 24'h760000, the required value of addr[31:8] for an in-range access.
REQ-002 The block SHALL have parameter IDX_W, default 6, the width of the word index addr[IDX_W+1:2] for 64 words.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port if_req_i  input  1  fetch-port (port 0) request.
REQ-006 The block SHALL have port if_addr_i  input  32  fetch-port byte address.
REQ-007 The block SHALL have port if_gnt_o  output  1  fetch-port grant (combinational, same cycle as request).
REQ-008 The block SHALL have ports if_rvalid_o  output  1, if_rdata_o  output  32, if_err_o  output  1: fetch-port response.
REQ-009 The block SHALL have ports dbg_req_i  input  1, dbg_addr_i  input  32, dbg_gnt_o  output  1: debug/loader port (port 1) request, address and grant.
REQ-010 The block SHALL have ports dbg_rvalid_o  output  1, dbg_rdata_o  output  32, dbg_err_o  output  1: debug-port response.
REQ-011 The block SHALL have port dbg_lock_i  input  1  debug requests exclusive ownership after its next grant.
REQ-012 The block SHALL have port mem_addr_o  output  32  address to the instruction memory.
REQ-013 The block SHALL have port mem_rd_i  input  32  combinational read data from the instruction memory.

Function
REQ-014 Handshake: a requester SHALL hold req and addr stable until gnt; a transfer occurs in any cycle with req && gnt.
REQ-015 At most one gnt SHALL be high per cycle; gnt SHALL never be high without its req.
REQ-016 Arbitration, both requesting, no lock: grant goes to the port not granted last (round-robin); last_gnt register updates on every transfer.
REQ-017 Single requester, no lock: that requester is granted in the same cycle.
REQ-018 Lock: an OWNED flag SHALL be set on a debug transfer with dbg_lock_i=1; while OWNED, if_gnt_o=0.
REQ-019 OWNED SHALL clear in the first cycle dbg_lock_i=0; fetch may be granted in that same cycle.
REQ-020 States: IDLE (no response pending), RESP (response pending); a transfer in any state moves to/stays in RESP next cycle; no transfer moves to IDLE.
REQ-021 Latency: a transfer in cycle N SHALL produce exactly one rvalid pulse on the granted port in cycle N+1; back-to-back transfers every cycle SHALL be supported.
REQ-022 In RESP, mem_addr_o SHALL equal the registered granted address; in IDLE mem_addr_o SHALL be 32'h0.
REQ-023 In-range: registered addr[31:8]==BASE_HI and addr[1:0]==2'b00; rdata SHALL equal mem_rd_i, err=0.
REQ-024 Out-of-range or misaligned: rdata SHALL be 32'h0, err=1, rvalid still pulses once.
REQ-025 rdata and err of a port SHALL be 0 whenever its rvalid is 0.
REQ-026 Index wrap: only addr[IDX_W+1:2] selects the word; 0x760000FC is the last valid word, 0x76000100 is out of range.

Reset
REQ-027 While rst_n_i=0, asynchronously: state=IDLE, OWNED=0, last_gnt=port 1, all rvalid/rdata/err=0, mem_addr_o=0.
REQ-028 A response pending at reset assertion SHALL be dropped, never delivered after release.
REQ-029 First contended request after reset SHALL be granted to the fetch port.

Verification
REQ-030 Reset release, if_req_i=1, if_addr_i=0x76000004, mem_rd_i=0x00500093 -> if_gnt_o=1 cycle 0, if_rvalid_o=1, if_rdata_o=0x00500093, if_err_o=0 cycle 1.
REQ-031 Both ports request 4 consecutive cycles -> grants alternate if,dbg,if,dbg; four rvalid pulses, one per cycle, on matching ports.
REQ-032 dbg_addr_i=0x76000100, then 0x76000002 -> dbg_rvalid_o=1, dbg_err_o=1, dbg_rdata_o=0 for both.
REQ-033 dbg_lock_i=1 with debug granted, if_req_i=1 held 5 cycles -> if_gnt_o=0 throughout; dbg_lock_i=0 -> if_gnt_o=1 that cycle.
REQ-034 rst_n_i pulled low in cycle after a transfer -> if_rvalid_o=0 immediately, no response after release.
REQ-035 No requests for 3 cycles -> all rvalid=0, mem_addr_o=0, state IDLE.

Source files
------------

// File: rtl/miriscv_im_arb.sv
// Two-port instruction-memory arbiter: fetch (port 0) and debug/loader
// (port 1) share one combinationally-read instruction memory. Grants are
// same-cycle, responses arrive exactly one cycle after the transfer, and the
// debug port can take exclusive ownership by holding dbg_lock_i.
module miriscv_im_arb #(
  parameter logic [23:0] BASE_HI = 24'h760000,
  parameter int          IDX_W   = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  input  logic        dbg_lock_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic        owned;      // debug holds exclusive ownership
  logic        last_gnt;   // 0: fetch granted last, 1: debug granted last
  logic        resp_port;  // port owed the pending response
  logic [31:0] addr_p0;    // address of the transfer being answered
  logic        lock_eff;
  logic        xfer;
  logic        in_range;
  logic        resp_ok;

  // Ownership drops in the very cycle the lock request is withdrawn.
  assign lock_eff = owned & dbg_lock_i;
  assign xfer     = if_gnt_o | dbg_gnt_o;

  // Same-cycle grant: lock first, then round-robin on contention.
  always_comb begin
    if_gnt_o  = 1'b0;
    dbg_gnt_o = 1'b0;
    if (lock_eff) begin
      dbg_gnt_o = dbg_req_i;
    end else if (if_req_i && dbg_req_i) begin
      if_gnt_o  = last_gnt;
      dbg_gnt_o = ~last_gnt;
    end else begin
      if_gnt_o  = if_req_i;
      dbg_gnt_o = dbg_req_i;
    end
  end

  // Control state: response FSM, arbitration history and ownership.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      owned     <= 1'b0;
      last_gnt  <= 1'b1;
      resp_port <= 1'b0;
    end else begin
      if (xfer) begin
        state     <= RESP;
        resp_port <= dbg_gnt_o;
        last_gnt  <= dbg_gnt_o;
      end else begin
        state <= IDLE;
      end
      if (!dbg_lock_i) begin
        owned <= 1'b0;
      end else if (dbg_gnt_o) begin
        owned <= 1'b1;
      end
    end
  end

  // Granted address capture; only observed while a response is pending.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      addr_p0 <= dbg_gnt_o ? dbg_addr_i : if_addr_i;
    end
  end

  // Window match, word alignment, and word index within the memory depth.
  always_comb begin
    in_range = (addr_p0[31:8] == BASE_HI) && (addr_p0[1:0] == 2'b00) &&
               ({26'd0, addr_p0[7:2]} < (32'd1 << IDX_W));
  end

  // Response stage: route memory data to the port owed the response.
  always_comb begin
    if_rvalid_o  = (state == RESP) && !resp_port;
    dbg_rvalid_o = (state == RESP) && resp_port;
    resp_ok      = (state == RESP) && in_range;
    if_rdata_o   = (if_rvalid_o && resp_ok) ? mem_rd_i : 32'h0;
    dbg_rdata_o  = (dbg_rvalid_o && resp_ok) ? mem_rd_i : 32'h0;
    if_err_o     = if_rvalid_o && !in_range;
    dbg_err_o    = dbg_rvalid_o && !in_range;
    mem_addr_o   = (state == RESP) ? addr_p0 : 32'h0;
  end

endmodule

// File: tb/tb_miriscv_im_arb.sv
// Bench for miriscv_im_arb: directed vector table, lock and reset
// sequences, then constrained-random traffic against a transaction model.
module tb_miriscv_im_arb;

  localparam logic [23:0] BASE_HI = 24'h760000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dbg_req, dbg_lock;
  logic [31:0] if_addr, dbg_addr, mem_rd;
  logic        if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] if_rdata, dbg_rdata, mem_addr;

  always #5 clk = ~clk;

  miriscv_im_arb #(.BASE_HI(BASE_HI), .IDX_W(6)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .dbg_lock_i(dbg_lock), .mem_addr_o(mem_addr), .mem_rd_i(mem_rd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: outstanding responses as a queue, who-went-last,
  // and whether debug currently owns the memory.
  typedef struct { int port; logic [31:0] addr; } resp_t;
  resp_t pend[$];
  int    m_last  = 1;
  bit    m_owned = 0;
  bit    eg_if, eg_dbg;

  function automatic bit addr_ok(logic [31:0] a);
    return (a[31:8] == BASE_HI) && (a[1:0] == 2'b00);
  endfunction

  // Drive one cycle's inputs, then compare all outputs against the model.
  task automatic apply(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                       logic dl, logic [31:0] md);
    logic        e_iv, e_dv, e_err;
    logic [31:0] e_rd, e_ma;
    bit          lk;
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    dbg_lock = dl; mem_rd = md;
    #1;
    e_iv = 0; e_dv = 0; e_err = 0; e_rd = 0; e_ma = 0;
    if (pend.size() > 0) begin
      e_ma  = pend[0].addr;
      e_err = !addr_ok(pend[0].addr);
      e_rd  = e_err ? 32'h0 : md;
      if (pend[0].port == 0) e_iv = 1; else e_dv = 1;
    end
    chk("m_if_rvalid", if_rvalid, e_iv);
    chk("m_dbg_rvalid", dbg_rvalid, e_dv);
    chk("m_if_rdata", if_rdata, e_iv ? e_rd : 32'h0);
    chk("m_dbg_rdata", dbg_rdata, e_dv ? e_rd : 32'h0);
    chk("m_if_err", if_err, e_iv & e_err);
    chk("m_dbg_err", dbg_err, e_dv & e_err);
    chk("m_mem_addr", mem_addr, e_ma);
    lk = m_owned && dl;
    if (lk) begin
      eg_if = 0; eg_dbg = dr;
    end else if (ir && dr) begin
      eg_if = (m_last == 1); eg_dbg = !eg_if;
    end else begin
      eg_if = ir; eg_dbg = dr;
    end
    chk("m_if_gnt", if_gnt, eg_if);
    chk("m_dbg_gnt", dbg_gnt, eg_dbg);
  endtask

  // Clock edge: retire the delivered response, record the new transfer.
  task automatic advance();
    @(posedge clk);
    if (pend.size() > 0) void'(pend.pop_front());
    if (eg_if && if_req) begin
      pend.push_back('{port: 0, addr: if_addr});
      m_last = 0;
    end
    if (eg_dbg && dbg_req) begin
      pend.push_back('{port: 1, addr: dbg_addr});
      m_last = 1;
    end
    if (!dbg_lock) m_owned = 0;
    else if (eg_dbg && dbg_req) m_owned = 1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ir; logic [31:0] ia; logic dr; logic [31:0] da; logic dl;
    logic [31:0] md;
    logic        ig, dg, iv, dv; logic [31:0] rd; logic er; logic [31:0] ma;
  } vec_t;
  vec_t tv[13];

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return {24'h760000, 8'($urandom_range(0, 255))};
      2:       return {24'h760001, 6'($urandom_range(0, 63)), 2'b00};
      default: return {24'h760000, 6'($urandom_range(0, 63)), 2'b00};
    endcase
  endfunction

  initial begin
    logic        ir, dr, dl;
    logic [31:0] ia, da;

    //           ir ia            dr da            dl md
    //           ig dg iv dv rd            er ma
    tv[0]  = '{1, 32'h76000004, 0, 32'h0,        0, 32'h00500093,
               1, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[1]  = '{0, 32'h0,        0, 32'h0,        0, 32'h00500093,
               0, 0, 1, 0, 32'h00500093, 0, 32'h76000004};
    tv[2]  = '{1, 32'h76000008, 1, 32'h7600000C, 0, 32'h11111111,
               0, 1, 0, 0, 32'h0,        0, 32'h0};
    tv[3]  = '{1, 32'h76000008, 1, 32'h7600000C, 0, 32'h22222222,
               1, 0, 0, 1, 32'h22222222, 0, 32'h7600000C};
    tv[4]  = '{1, 32'h76000010, 1, 32'h7600000C, 0, 32'h33333333,
               0, 1, 1, 0, 32'h33333333, 0, 32'h76000008};
    tv[5]  = '{1, 32'h76000010, 1, 32'h760000FC, 0, 32'h44444444,
               1, 0, 0, 1, 32'h44444444, 0, 32'h7600000C};
    tv[6]  = '{0, 32'h0,        1, 32'h760000FC, 0, 32'h55555555,
               0, 1, 1, 0, 32'h55555555, 0, 32'h76000010};
    tv[7]  = '{0, 32'h0,        1, 32'h76000100, 0, 32'h66666666,
               0, 1, 0, 1, 32'h66666666, 0, 32'h760000FC};
    tv[8]  = '{0, 32'h0,        1, 32'h76000002, 0, 32'h77777777,
               0, 1, 0, 1, 32'h0,        1, 32'h76000100};
    tv[9]  = '{0, 32'h0,        0, 32'h0,        0, 32'h88888888,
               0, 0, 0, 1, 32'h0,        1, 32'h76000002};
    tv[10] = '{0, 32'h0,        0, 32'h0,        0, 32'h99999999,
               0, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[11] = '{0, 32'h0,        0, 32'h0,        0, 32'hAAAAAAAA,
               0, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[12] = '{0, 32'h0,        0, 32'h0,        0, 32'hBBBBBBBB,
               0, 0, 0, 0, 32'h0,        0, 32'h0};

    rst_n = 0; if_req = 0; if_addr = 0; dbg_req = 0; dbg_addr = 0;
    dbg_lock = 0; mem_rd = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dbg_err", dbg_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      apply(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].da, tv[i].dl, tv[i].md);
      chk($sformatf("v%0d_if_gnt", i), if_gnt, tv[i].ig);
      chk($sformatf("v%0d_dbg_gnt", i), dbg_gnt, tv[i].dg);
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid, tv[i].iv);
      chk($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid, tv[i].dv);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, tv[i].iv ? tv[i].rd : 32'h0);
      chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, tv[i].dv ? tv[i].rd : 32'h0);
      chk($sformatf("v%0d_if_err", i), if_err, tv[i].iv & tv[i].er);
      chk($sformatf("v%0d_dbg_err", i), dbg_err, tv[i].dv & tv[i].er);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ma);
      advance();
    end

    // Debug takes ownership; fetch starves until the lock is withdrawn.
    apply(0, 32'h0, 1, 32'h76000020, 1, 32'h12345678);
    chk("lock_dbg_gnt", dbg_gnt, 1);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'h76000024, 0, 32'h0, 1, 32'h0BADF00D);
      chk($sformatf("lock_if_gnt%0d", i), if_gnt, 0);
      advance();
    end
    apply(1, 32'h76000024, 0, 32'h0, 0, 32'h0BADF00D);
    chk("unlock_if_gnt", if_gnt, 1);
    advance();
    apply(0, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D);
    chk("unlock_if_rvalid", if_rvalid, 1);
    advance();

    // Reset while a fetch response is on the outputs: it must vanish.
    apply(1, 32'h76000028, 0, 32'h0, 0, 32'h0);
    advance();
    apply(0, 32'h0, 0, 32'h0, 0, 32'h13579BDF);
    chk("pre_rst_if_rvalid", if_rvalid, 1);
    rst_n = 0;
    #1;
    chk("async_rst_if_rvalid", if_rvalid, 0);
    chk("async_rst_if_rdata", if_rdata, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    pend.delete(); m_owned = 0; m_last = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      apply(0, 32'h0, 0, 32'h0, 0, 32'h2468ACE0);
      chk($sformatf("post_rst_if_rvalid%0d", i), if_rvalid, 0);
      advance();
    end
    apply(1, 32'h76000030, 1, 32'h76000034, 0, 32'h0);
    chk("post_rst_first_if_gnt", if_gnt, 1);
    chk("post_rst_first_dbg_gnt", dbg_gnt, 0);
    advance();

    // Random traffic; an ungranted requester holds its request and address.
    ir = 0; dr = 0; dl = 0; ia = 0; da = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(ir && !eg_if)) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = raddr();
      end
      if (!(dr && !eg_dbg)) begin
        dr = ($urandom_range(0, 2) != 0);
        da = raddr();
      end
      if (dl) dl = ($urandom_range(0, 3) != 0);
      else    dl = ($urandom_range(0, 7) == 0);
      apply(ir, ia, dr, da, dl, $urandom);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
